// File: rtl/dp_demx16q.sv
// dp_demx16q: 16-bit output stage, 2-entry in-order queue steering each word
// to port 0 or port 1 by its tag, valid/ready on both sides.
//
// Ports:
//   clk, reset_l             clock, async active-low reset
//   in_data/in_dest          word and destination tag from the producer
//   in_valid/in_ready        producer handshake (ready is registered)
//   out0_data/valid/ready    consumer port 0
//   out1_data/valid/ready    consumer port 1
//   count                    entries held (0..2)

module dp_demx16q (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [15:0] in_data,
  input  logic        in_dest,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out0_data,
  output logic        out0_valid,
  input  logic        out0_ready,
  output logic [15:0] out1_data,
  output logic        out1_valid,
  input  logic        out1_ready,
  output logic [1:0]  count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic        ready_q;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [15:0] mem_data [2];
  logic [1:0]  mem_tag;

  logic        live;
  logic        head_tag;
  logic        rd_sel;
  logic        push;
  logic        pop;

  assign live     = (state != EMPTY);
  assign head_tag = mem_tag[rd_ptr];

  assign out0_valid = live & ~head_tag;
  assign out1_valid = live & head_tag;

  assign push = in_valid & ready_q;
  assign pop  = (out0_valid & out0_ready)
              | (out1_valid & out1_ready);

  // Empty is only reached by popping, so the last head sits
  // just behind the read pointer; show it while idle.
  assign rd_sel    = live ? rd_ptr : ~rd_ptr;
  assign out0_data = mem_data[rd_sel];
  assign out1_data = mem_data[rd_sel];

  assign in_ready = ready_q;
  assign count    = state;

  // in_ready is registered alongside the state so it never
  // sees out*_ready combinationally.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push)
            state <= ONE;
        end
        ONE: begin
          if (push && !pop) begin
            state   <= FULL;
            ready_q <= 1'b0;
          end else if (pop && !push) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state   <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      mem_data[0] <= 16'h0000;
      mem_data[1] <= 16'h0000;
      mem_tag     <= 2'b00;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_tag[wr_ptr]  <= in_dest;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_dp_demx16q.sv
// tb_dp_demx16q: bench for dp_demx16q, vector table plus
// queue-model scoreboard over directed and random traffic.

module tb_dp_demx16q;

  logic        clk;
  logic        reset_l;
  logic [15:0] in_data;
  logic        in_dest;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [1:0]  count;

  dp_demx16q dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        t;
  } ent_t;

  ent_t mq[$];

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        dst;
    logic        r0;
    logic        r1;
    logic [1:0]  ecnt;
    logic        eir;
    logic        ev0;
    logic        ev1;
    logic [15:0] edata;
  } vec_t;

  vec_t vt[17];

  int checks;
  int errors;
  int delivered;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Check DUT against the queue model, clock once, update model.
  task automatic cycle();
    logic pu;
    logic po;
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
    if (mq.size() == 0) begin
      chk("v0_idle", 32'(out0_valid), 0);
      chk("v1_idle", 32'(out1_valid), 0);
    end else begin
      chk("v0", 32'(out0_valid), 32'(!mq[0].t));
      chk("v1", 32'(out1_valid), 32'(mq[0].t));
      if (mq[0].t)
        chk("d1", 32'(out1_data), 32'(mq[0].d));
      else
        chk("d0", 32'(out0_data), 32'(mq[0].d));
    end
    pu = in_valid && (mq.size() < 2);
    po = (mq.size() > 0) &&
         (mq[0].t ? out1_ready : out0_ready);
    @(posedge clk);
    if (po) begin
      void'(mq.pop_front());
      delivered++;
    end
    if (pu)
      mq.push_back('{d: in_data, t: in_dest});
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    delivered  = 0;
    reset_l    = 1'b0;
    in_data    = 16'h0;
    in_dest    = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    //       iv  data     dst r0 r1 cnt ir v0 v1 data
    vt[0]  = '{1, 16'hA5A5, 0, 1, 1, 1, 1, 1, 0, 16'hA5A5};
    vt[1]  = '{1, 16'h5A5A, 1, 1, 1, 1, 1, 0, 1, 16'h5A5A};
    vt[2]  = '{0, 16'h0000, 0, 1, 1, 0, 1, 0, 0, 16'h5A5A};
    vt[3]  = '{1, 16'h0001, 0, 0, 0, 1, 1, 1, 0, 16'h0001};
    vt[4]  = '{1, 16'h0002, 0, 0, 0, 2, 0, 1, 0, 16'h0001};
    vt[5]  = '{1, 16'h0003, 0, 0, 0, 2, 0, 1, 0, 16'h0001};
    vt[6]  = '{1, 16'h0003, 0, 1, 0, 1, 1, 1, 0, 16'h0002};
    vt[7]  = '{1, 16'h0003, 0, 1, 0, 1, 1, 1, 0, 16'h0003};
    vt[8]  = '{0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, 16'h0003};
    vt[9]  = '{1, 16'h1111, 1, 1, 0, 1, 1, 0, 1, 16'h1111};
    vt[10] = '{1, 16'h2222, 0, 1, 0, 2, 0, 0, 1, 16'h1111};
    vt[11] = '{0, 16'h0000, 0, 1, 0, 2, 0, 0, 1, 16'h1111};
    vt[12] = '{0, 16'h0000, 0, 1, 1, 1, 1, 1, 0, 16'h2222};
    vt[13] = '{0, 16'h0000, 0, 1, 1, 0, 1, 0, 0, 16'h2222};
    vt[14] = '{1, 16'hCAFE, 1, 0, 0, 1, 1, 0, 1, 16'hCAFE};
    vt[15] = '{1, 16'hBEEF, 0, 0, 1, 1, 1, 1, 0, 16'hBEEF};
    vt[16] = '{0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, 16'hBEEF};

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_ir", 32'(in_ready), 1);
    chk("rst_v0", 32'(out0_valid), 0);
    chk("rst_v1", 32'(out1_valid), 0);
    chk("rst_d0", 32'(out0_data), 0);
    chk("rst_d1", 32'(out1_data), 0);
    @(negedge clk);
    reset_l = 1'b1;

    for (int i = 0; i < 17; i++) begin
      in_valid   = vt[i].iv;
      in_data    = vt[i].d;
      in_dest    = vt[i].dst;
      out0_ready = vt[i].r0;
      out1_ready = vt[i].r1;
      cycle();
      chk($sformatf("vec%0d_cnt", i), 32'(count), 32'(vt[i].ecnt));
      chk($sformatf("vec%0d_ir", i), 32'(in_ready), 32'(vt[i].eir));
      chk($sformatf("vec%0d_v0", i), 32'(out0_valid), 32'(vt[i].ev0));
      chk($sformatf("vec%0d_v1", i), 32'(out1_valid), 32'(vt[i].ev1));
      if (vt[i].ev1)
        chk($sformatf("vec%0d_d1", i), 32'(out1_data), 32'(vt[i].edata));
      else
        chk($sformatf("vec%0d_d0", i), 32'(out0_data), 32'(vt[i].edata));
    end

    // Fill to two, then reset between clock edges.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_data    = 16'h7777;
    in_dest    = 1'b1;
    cycle();
    in_data    = 16'h8888;
    in_dest    = 1'b0;
    cycle();
    in_valid   = 1'b0;
    chk("pre_rst_count", 32'(count), 2);
    #2;
    reset_l = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_v0", 32'(out0_valid), 0);
    chk("mid_rst_v1", 32'(out1_valid), 0);
    chk("mid_rst_ir", 32'(in_ready), 1);
    chk("mid_rst_d0", 32'(out0_data), 0);
    chk("mid_rst_d1", 32'(out1_data), 0);
    mq.delete();
    @(negedge clk);
    reset_l = 1'b1;

    // Sustained stream, alternating tags.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    delivered  = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i * 16'h0123 + 16'h0F00);
      in_dest  = i[0];
      cycle();
      if (count > 2'd1)
        chk("stream_cnt_le1", 32'(count), 1);
    end
    in_valid = 1'b0;
    chk("stream_rate", 32'(delivered), 63);
    cycle();
    chk("stream_total", 32'(delivered), 64);
    chk("stream_empty", 32'(count), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = 16'($urandom);
      in_dest    = 1'($urandom_range(0, 1));
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      cycle();
    chk("final_empty", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_demx16q.md
# dp_demx16q

16-bit datapath output stage that steers a stream of words, each tagged with a destination bit, to one of two consumers through a 2-entry in-order queue. It is the unload end of the 2-to-1 loading register: that register selects one of two sources into a word, and this block delivers a word to one of two sinks. Both sides use valid/ready handshakes, so producer and consumers can stall independently. The block sits between the BCP vector datapath result registers and the two downstream consumers.

## Interface
- Parameters: none; data width fixed at 16 bits, depth fixed at 2 entries.
- clk  input  1  sole clock; all state updates on the rising edge
- reset_l  input  1  asynchronous, active-low reset
- in_data  input  16  word offered by the producer
- in_dest  input  1  destination tag for in_data (0 = port 0, 1 = port 1)
- in_valid  input  1  producer offers in_data/in_dest this cycle
- in_ready  output  1  block accepts a word this cycle
- out0_data  output  16  head word, meaningful when out0_valid=1
- out0_valid  output  1  head word is destined for port 0
- out0_ready  input  1  port 0 consumer accepts
- out1_data  output  16  head word, meaningful when out1_valid=1
- out1_valid  output  1  head word is destined for port 1
- out1_ready  input  1  port 1 consumer accepts
- count  output  2  entries held (0, 1 or 2)

## Operation
- Storage: two 16+1-bit entries (data plus tag), organised as a circular buffer with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count. A shift structure is also acceptable if externally identical.
- States, encoded by count:
  - EMPTY (0)
  - ONE (1)
  - FULL (2)
- Push: occurs when in_valid & in_ready. Data and tag are written at the write pointer, then the write pointer toggles.
- Pop: occurs when (out0_valid & out0_ready) | (out1_valid & out1_ready). The read pointer toggles.
- Transitions:
  - EMPTY + push → ONE
  - ONE + push only → FULL
  - ONE + pop only → EMPTY
  - ONE + push + pop → ONE
  - FULL + pop → ONE
  - All other cases hold the current state.
- in_ready = (count != 2). It is a function of state only. It has no combinational path from out*_ready, so a push never occurs in the same cycle a pop frees a FULL queue.
- Output valids:
  - out0_valid = (count != 0) & ~head_tag
  - out1_valid = (count != 0) & head_tag
  - At most one is high in any cycle.
- out0_data and out1_data both equal the head entry data.
- When count = 0, the data outputs hold the last head value. Neither consumer may sample data while its valid is low.
- The ready of the non-selected port is ignored. A head word destined for port 1 blocks port 0 traffic behind it, because delivery is strictly in order.
- Once a valid is asserted, it and the corresponding data remain stable until the matching ready is sampled high.
- in_dest and in_data are ignored when there is no push.
- No overflow or underflow is possible:
  - A push is blocked when FULL.
  - A pop requires a valid, which requires count != 0.

## Timing
- Reset (reset_l low, asynchronous):
  - count = 0, both pointers = 0, all stored entries = 0.
  - out0_valid = out1_valid = 0, out0_data = out1_data = 16'h0000, in_ready = 1.
- After reset_l deasserts, the first push may occur on the first rising edge.
- Latency: a word pushed at edge N is visible on its port's valid/data after edge N (cycle N+1). There is no combinational input-to-output bypass.
- Throughput: one word per cycle sustained when the target consumer holds ready high.
- Reset asserted mid-operation discards all queued words immediately. Valids drop asynchronously with reset_l.
- All outputs come from registers, except:
  - out*_valid, decoded from count and the head tag;
  - out*_data, taken through a 2:1 read mux on the read pointer.

## Test plan
- Reset: assert reset_l=0 mid-stream with count=2. Required response: count=0, out0_valid=out1_valid=0, in_ready=1, data outputs=16'h0000, without waiting for a clock edge.
- Steering: push 16'hA5A5 with dest 0, then 16'h5A5A with dest 1, with both readies held high. Required response:
  - 16'hA5A5 appears on port 0 at cycle 1 after its push.
  - 16'h5A5A appears on port 1 at the following cycle.
  - The other port's valid stays 0 throughout.
- Fill and stall: hold both readies low and push 16'h0001, 16'h0002, 16'h0003. Required response:
  - in_ready drops after the second push, count=2.
  - The third word is held off by the producer.
  - Then raise out0_ready: words drain in order 1, 2, and word 3 is accepted the cycle after in_ready returns.
- Head-of-line blocking: queue dest 1 (16'h1111) then dest 0 (16'h2222), with out1_ready=0 and out0_ready=1. Required response:
  - out1_valid=1 and out0_valid=0 while stalled.
  - Raising out1_ready pops 16'h1111, then 16'h2222 appears on port 0.
- Simultaneous push/pop at count=1: push 16'hBEEF on the same edge the head pops. Required response: count stays 1, and 16'hBEEF becomes the head on the next cycle.
- Sustained streaming: 64 words with alternating tags and both readies high. Required response: one word delivered per cycle, order and per-port routing exact, count never exceeds 1.
